// File: rtl/btn_event_counter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// btn_event_counter
//
// Multi-channel button front end. Each channel has a 2-FF synchroniser, an
// early-detection debouncer with a lockout timer, selectable edge detection
// and an event counter (wrapping or saturating) with a sticky overflow flag.
//
// Parameters
//   N_CH       number of independent button channels
//   CNT_W      width of each event counter
//   DB_CYCLES  lockout length in clk cycles after an accepted level change (>= 2)
//   SATURATE   0: counter wraps to 0 on overflow, 1: counter holds at all-ones
//
// Ports
//   clk         system clock
//   rst_n       synchronous, active-low reset
//   btn         raw asynchronous button levels, one bit per channel
//   edge_mode   00 rising, 01 falling, 10 both, 11 counting disabled (shared)
//   clr         per-channel synchronous clear of cnt and ovf
//   db_level    debounced level per channel (registered)
//   event_tick  one-cycle pulse per counted edge (combinational from registers)
//   cnt         packed counters, channel i at [i*CNT_W +: CNT_W] (registered)
//   ovf         sticky overflow flag per channel (registered)
// ---------------------------------------------------------------------------
module btn_event_counter #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         btn,
  input  logic [1:0]              edge_mode,
  input  logic [N_CH-1:0]         clr,
  output logic [N_CH-1:0]         db_level,
  output logic [N_CH-1:0]         event_tick,
  output logic [N_CH*CNT_W-1:0]   cnt,
  output logic [N_CH-1:0]         ovf
);

  // Timer counts DB_CYCLES-1 down to 0, so $clog2(DB_CYCLES) bits suffice.
  localparam int unsigned   TW        = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [TW-1:0] LOCK_LOAD = TW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW,
    ST_WAIT_HI,
    ST_HIGH,
    ST_WAIT_LO
  } db_state_e;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch

    logic             sync1_q;
    logic             sync2_q;
    db_state_e        state_q;
    logic [TW-1:0]    timer_q;
    logic             db_q;
    logic             db_dly_q;
    logic             rise;
    logic             fall;
    logic             tick;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;

    // Two-stage synchroniser for the asynchronous button input.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= btn[g];
        sync2_q <= sync1_q;
      end
    end

    // Early-detection debouncer: the first level change is accepted at once,
    // then the synchronised input is ignored until the lockout timer expires.
    // A level still differing on return to HIGH/LOW flips on the next cycle.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_LOW;
        timer_q <= '0;
        db_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_LOW: begin
            if (sync2_q) begin
              db_q    <= 1'b1;
              timer_q <= LOCK_LOAD;
              state_q <= ST_WAIT_HI;
            end
          end
          ST_WAIT_HI: begin
            if (timer_q == '0) begin
              state_q <= ST_HIGH;
            end else begin
              timer_q <= timer_q - TW'(1);
            end
          end
          ST_HIGH: begin
            if (!sync2_q) begin
              db_q    <= 1'b0;
              timer_q <= LOCK_LOAD;
              state_q <= ST_WAIT_LO;
            end
          end
          ST_WAIT_LO: begin
            if (timer_q == '0) begin
              state_q <= ST_LOW;
            end else begin
              timer_q <= timer_q - TW'(1);
            end
          end
          default: begin
            state_q <= ST_LOW;
          end
        endcase
      end
    end

    // One-cycle delayed copy of the debounced level for edge detection.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        db_dly_q <= 1'b0;
      end else begin
        db_dly_q <= db_q;
      end
    end

    assign rise = db_q & ~db_dly_q;
    assign fall = ~db_q & db_dly_q;

    // edge_mode acts on the current cycle only; edges seen under a
    // different mode are not counted later.
    always_comb begin
      tick = 1'b0;
      case (edge_mode)
        2'b00:   tick = rise;
        2'b01:   tick = fall;
        2'b10:   tick = rise | fall;
        default: tick = 1'b0;
      endcase
    end

    // Counter next state: clear wins over an increment in the same cycle.
    always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr[g]) begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end else if (tick) begin
        if (cnt_q == '1) begin
          ovf_d = 1'b1;
          cnt_d = SATURATE ? '1 : '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign db_level[g]               = db_q;
    assign event_tick[g]             = tick;
    assign cnt[g*CNT_W +: CNT_W]     = cnt_q;
    assign ovf[g]                    = ovf_q;

  end : g_ch

endmodule

// File: tb/tb_btn_event_counter.sv
`timescale 1ns/1ps
module tb_btn_event_counter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn;
  logic [1:0]   edge_mode;
  logic [N-1:0] clr;

  logic [N-1:0]   db_w, tick_w, ovf_w;
  logic [N*W-1:0] cnt_w;
  logic [N-1:0]   db_s, tick_s, ovf_s;
  logic [N*W-1:0] cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_event_counter #(.N_CH(N), .CNT_W(W), .DB_CYCLES(DB), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .btn(btn), .edge_mode(edge_mode), .clr(clr),
    .db_level(db_w), .event_tick(tick_w), .cnt(cnt_w), .ovf(ovf_w));

  btn_event_counter #(.N_CH(N), .CNT_W(W), .DB_CYCLES(DB), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .btn(btn), .edge_mode(edge_mode), .clr(clr),
    .db_level(db_s), .event_tick(tick_s), .cnt(cnt_s), .ovf(ovf_s));

  // ---------------- reference model ----------------
  // Debounce as "accept a differing level once the previous acceptance is at
  // least DB+1 cycles old"; counting as a plain event total per channel.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_prev;
  longint       m_next [N];
  int           m_events [N];
  longint       cyc = 0;

  function automatic logic exp_tick(int ch);
    logic r, f;
    r = m_lvl[ch] & ~m_prev[ch];
    f = ~m_lvl[ch] & m_prev[ch];
    case (edge_mode)
      2'b00:   return r;
      2'b01:   return f;
      2'b10:   return r | f;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [N-1:0] exp_tick_vec();
    logic [N-1:0] v;
    for (int ch = 0; ch < N; ch++) v[ch] = exp_tick(ch);
    return v;
  endfunction

  function automatic logic [N*W-1:0] exp_cnt_vec(bit sat);
    logic [N*W-1:0] v;
    for (int ch = 0; ch < N; ch++) begin
      if (sat) v[ch*W +: W] = (m_events[ch] >= 255) ? W'(255) : W'(m_events[ch]);
      else     v[ch*W +: W] = W'(m_events[ch] % 256);
    end
    return v;
  endfunction

  function automatic logic [N-1:0] exp_ovf_vec();
    logic [N-1:0] v;
    for (int ch = 0; ch < N; ch++) v[ch] = (m_events[ch] >= 256);
    return v;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int ch = 0; ch < N; ch++) begin
      if (!rst_n) begin
        m_s1[ch]     <= 1'b0;
        m_s2[ch]     <= 1'b0;
        m_lvl[ch]    <= 1'b0;
        m_prev[ch]   <= 1'b0;
        m_next[ch]   <= 0;
        m_events[ch] <= 0;
      end else begin
        if (clr[ch])           m_events[ch] <= 0;
        else if (exp_tick(ch)) m_events[ch] <= m_events[ch] + 1;
        m_prev[ch] <= m_lvl[ch];
        if (cyc >= m_next[ch] && m_s2[ch] != m_lvl[ch]) begin
          m_lvl[ch]  <= m_s2[ch];
          m_next[ch] <= cyc + DB + 1;
        end
        m_s2[ch] <= m_s1[ch];
        m_s1[ch] <= btn[ch];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn = 4'($urandom); edge_mode = 2'b00; clr = '0;
    step(3);
    checks++;
    if ({db_w, tick_w, ovf_w, cnt_w} !== '0 || {db_s, tick_s, ovf_s, cnt_s} !== '0) begin
      errors++;
      $display("FAIL reset_state: wrap db=%b tick=%b ovf=%b cnt=%h sat db=%b tick=%b ovf=%b cnt=%h expected all 0",
               db_w, tick_w, ovf_w, cnt_w, db_s, tick_s, ovf_s, cnt_s);
    end
    btn = '0;
    step(1);
    rst_n = 1'b1;
    step(4);
  endtask

  task automatic test_clean_press();
    int ticks;
    edge_mode = 2'b00; clr = '1; step(1); clr = '0;
    btn[0] = 1'b1;
    step(2);
    checks++;
    if (db_w[0] !== 1'b0) begin
      errors++; $display("FAIL press_early: db_level[0]=%b expected 0 after 2 edges", db_w[0]);
    end
    step(1);
    checks++;
    if ({db_w[0], tick_w[0], db_s[0], tick_s[0]} !== 4'b1111) begin
      errors++; $display("FAIL press_edge3: db=%b tick=%b (sat db=%b tick=%b) expected 1 1",
                         db_w[0], tick_w[0], db_s[0], tick_s[0]);
    end
    step(1);
    checks++;
    if (tick_w[0] !== 1'b0 || cnt_w[7:0] !== 8'd1 || cnt_s[7:0] !== 8'd1) begin
      errors++; $display("FAIL press_count: tick=%b cnt_w=%0d cnt_s=%0d expected tick 0 cnt 1",
                         tick_w[0], cnt_w[7:0], cnt_s[7:0]);
    end
    ticks = 0;
    for (int i = 0; i < 8; i++) begin step(1); ticks += int'(tick_w[0]); end
    btn[0] = 1'b0;
    step(2);
    checks++;
    if (db_w[0] !== 1'b1) begin
      errors++; $display("FAIL release_early: db_level[0]=%b expected 1", db_w[0]);
    end
    step(1);
    checks++;
    if (db_w[0] !== 1'b0) begin
      errors++; $display("FAIL release_edge3: db_level[0]=%b expected 0", db_w[0]);
    end
    for (int i = 0; i < 8; i++) begin step(1); ticks += int'(tick_w[0]); end
    checks++;
    if (ticks != 0 || cnt_w[7:0] !== 8'd1 || cnt_s[7:0] !== 8'd1) begin
      errors++; $display("FAIL release_no_count: extra ticks=%0d cnt_w=%0d cnt_s=%0d expected 0 ticks cnt 1",
                         ticks, cnt_w[7:0], cnt_s[7:0]);
    end
  endtask

  task automatic test_bounce();
    int rises, falls, rise_at, fall_at;
    logic pv;
    edge_mode = 2'b00; clr = '1; step(1); clr = '0;
    rises = 0; falls = 0; pv = db_w[1];
    for (int k = 0; k < 17; k++) begin
      btn[1] = (k < 5) ? (k % 2 == 0) : 1'b1;
      step(1);
      if (db_w[1] && !pv) rises++;
      if (!db_w[1] && pv) falls++;
      pv = db_w[1];
    end
    checks++;
    if (rises != 1 || falls != 0 || cnt_w[15:8] !== 8'd1 || cnt_s[15:8] !== 8'd1) begin
      errors++; $display("FAIL bounce_hold_high: rises=%0d falls=%0d cnt=%0d expected 1 0 1",
                         rises, falls, cnt_w[15:8]);
    end
    btn[1] = 1'b0; step(12);
    clr = '1; step(1); clr = '0;
    rises = 0; falls = 0; rise_at = -1; fall_at = -1; pv = db_w[1];
    for (int k = 0; k < 17; k++) begin
      btn[1] = (k < 5) ? (k % 2 == 0) : 1'b0;
      step(1);
      if (db_w[1] && !pv) begin rises++; rise_at = k; end
      if (!db_w[1] && pv) begin falls++; fall_at = k; end
      pv = db_w[1];
    end
    checks++;
    if (rises != 1 || falls != 1 || (fall_at - rise_at) != DB + 1 || cnt_w[15:8] !== 8'd1) begin
      errors++; $display("FAIL bounce_then_low: rises=%0d falls=%0d gap=%0d cnt=%0d expected 1 1 %0d 1",
                         rises, falls, fall_at - rise_at, cnt_w[15:8], DB + 1);
    end
  endtask

  task automatic test_edge_modes();
    logic [1:0] modes [3];
    int exp_cnt [3];
    int press_ticks, rel_ticks;
    modes = '{2'b10, 2'b01, 2'b11};
    exp_cnt = '{2, 1, 0};
    for (int m = 0; m < 3; m++) begin
      edge_mode = modes[m];
      clr[2] = 1'b1; step(1); clr[2] = 1'b0;
      press_ticks = 0; rel_ticks = 0;
      btn[2] = 1'b1;
      for (int i = 0; i < 10; i++) begin step(1); press_ticks += int'(tick_w[2]); end
      btn[2] = 1'b0;
      for (int i = 0; i < 10; i++) begin step(1); rel_ticks += int'(tick_w[2]); end
      checks++;
      if (cnt_w[23:16] !== 8'(exp_cnt[m]) || cnt_s[23:16] !== 8'(exp_cnt[m]) ||
          press_ticks + rel_ticks != exp_cnt[m] || (modes[m] == 2'b01 && press_ticks != 0)) begin
        errors++; $display("FAIL edge_mode_%b: cnt=%0d press_ticks=%0d rel_ticks=%0d expected cnt %0d",
                           modes[m], cnt_w[23:16], press_ticks, rel_ticks, exp_cnt[m]);
      end
    end
    edge_mode = 2'b00;
  endtask

  task automatic test_overflow();
    edge_mode = 2'b00; clr[3] = 1'b1; step(1); clr[3] = 1'b0;
    for (int p = 0; p < 255; p++) begin
      btn[3] = 1'b1; step(8); btn[3] = 1'b0; step(8);
    end
    checks++;
    if (cnt_w[31:24] !== 8'hFF || ovf_w[3] !== 1'b0 || cnt_s[31:24] !== 8'hFF || ovf_s[3] !== 1'b0) begin
      errors++; $display("FAIL ovf_255: wrap cnt=%h ovf=%b sat cnt=%h ovf=%b expected FF 0 FF 0",
                         cnt_w[31:24], ovf_w[3], cnt_s[31:24], ovf_s[3]);
    end
    btn[3] = 1'b1; step(8); btn[3] = 1'b0; step(8);
    checks++;
    if (cnt_w[31:24] !== 8'h00 || ovf_w[3] !== 1'b1) begin
      errors++; $display("FAIL ovf_wrap_256: cnt=%h ovf=%b expected 00 1", cnt_w[31:24], ovf_w[3]);
    end
    checks++;
    if (cnt_s[31:24] !== 8'hFF || ovf_s[3] !== 1'b1) begin
      errors++; $display("FAIL ovf_sat_256: cnt=%h ovf=%b expected FF 1", cnt_s[31:24], ovf_s[3]);
    end
    btn[3] = 1'b1; step(8); btn[3] = 1'b0; step(8);
    checks++;
    if (cnt_w[31:24] !== 8'h01 || ovf_w[3] !== 1'b1 || cnt_s[31:24] !== 8'hFF || ovf_s[3] !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: wrap cnt=%h ovf=%b sat cnt=%h ovf=%b expected 01 1 FF 1",
                         cnt_w[31:24], ovf_w[3], cnt_s[31:24], ovf_s[3]);
    end
    clr[3] = 1'b1; step(1); clr[3] = 1'b0;
    checks++;
    if (cnt_w[31:24] !== 8'h00 || ovf_w[3] !== 1'b0 || cnt_s[31:24] !== 8'h00 || ovf_s[3] !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: wrap cnt=%h ovf=%b sat cnt=%h ovf=%b expected 00 0",
                         cnt_w[31:24], ovf_w[3], cnt_s[31:24], ovf_s[3]);
    end
  endtask

  task automatic test_priority();
    bit seen;
    edge_mode = 2'b00; clr = '1; step(1); clr = '0;
    btn[2] = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1);
      if (tick_w[2]) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL clr_priority_tick: event_tick[2]=0 within 10 cycles, expected 1");
    end
    clr[2] = 1'b1; step(1); clr[2] = 1'b0;
    checks++;
    if (cnt_w[23:16] !== 8'd0 || cnt_s[23:16] !== 8'd0) begin
      errors++; $display("FAIL clr_priority: cnt_w=%0d cnt_s=%0d expected 0", cnt_w[23:16], cnt_s[23:16]);
    end
    step(10); btn[2] = 1'b0; step(10);
    clr = '1; step(1); clr = '0;
    btn = 4'b1001; step(10);
    checks++;
    if (cnt_w !== 32'h01000001 || cnt_s !== 32'h01000001) begin
      errors++; $display("FAIL simultaneous: cnt_w=%h cnt_s=%h expected 01000001", cnt_w, cnt_s);
    end
    btn = '0; step(10);
  endtask

  task automatic test_reset_lockout();
    bit seen;
    edge_mode = 2'b00; clr = '1; step(1); clr = '0;
    btn[0] = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1);
      if (db_w[0]) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rst_lock_rise: db_level[0]=0 within 10 cycles, expected 1");
    end
    step(1);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1);
      checks++;
      if ({db_w, tick_w, ovf_w, cnt_w} !== '0 || {db_s, tick_s, ovf_s, cnt_s} !== '0) begin
        errors++; $display("FAIL rst_lock_outputs: db=%b tick=%b ovf=%b cnt=%h expected all 0",
                           db_w, tick_w, ovf_w, cnt_w);
      end
    end
    rst_n = 1'b1;
    step(2);
    checks++;
    if (db_w[0] !== 1'b0) begin
      errors++; $display("FAIL rst_lock_early: db_level[0]=%b expected 0", db_w[0]);
    end
    step(1);
    checks++;
    if (db_w[0] !== 1'b1 || db_s[0] !== 1'b1) begin
      errors++; $display("FAIL rst_lock_rerise: db_level[0]=%b expected 1", db_w[0]);
    end
    step(1);
    checks++;
    if (cnt_w[7:0] !== 8'd1 || cnt_s[7:0] !== 8'd1) begin
      errors++; $display("FAIL rst_lock_count: cnt=%0d expected 1", cnt_w[7:0]);
    end
    btn = '0; step(10);
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      step(1);
      checks++;
      if (db_w !== m_lvl || db_s !== m_lvl || tick_w !== exp_tick_vec() || tick_s !== exp_tick_vec()) begin
        errors++; $display("FAIL rand_db_tick cyc %0d: db=%b/%b tick=%b/%b expected db %b tick %b",
                           c, db_w, db_s, tick_w, tick_s, m_lvl, exp_tick_vec());
      end
      checks++;
      if (cnt_w !== exp_cnt_vec(1'b0) || ovf_w !== exp_ovf_vec() ||
          cnt_s !== exp_cnt_vec(1'b1) || ovf_s !== exp_ovf_vec()) begin
        errors++; $display("FAIL rand_cnt cyc %0d: wrap %h/%b sat %h/%b expected wrap %h sat %h ovf %b",
                           c, cnt_w, ovf_w, cnt_s, ovf_s, exp_cnt_vec(1'b0), exp_cnt_vec(1'b1), exp_ovf_vec());
      end
      for (int ch = 0; ch < N; ch++) begin
        if ($urandom_range(0, 5) == 0) btn[ch] = ~btn[ch];
        clr[ch] = ($urandom_range(0, 59) == 0);
      end
      if ($urandom_range(0, 49) == 0) edge_mode = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 399) != 0);
    end
    rst_n = 1'b1; clr = '0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_edge_modes();
    test_overflow();
    test_priority();
    test_reset_lockout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
